awg_seg_sequencer: RTL and testbench
====================================

AWG_SEG_SEQUENCER -- requirements
Module: awg_seg_sequencer

Interface
REQ-001 Parameter DW, default 24: width of delay, length and address fields.
REQ-002 Parameter NSEG, default 3: number of segments per playback; fixed at 3 for this revision.
REQ-003 Single clock, reset asynchronous active-low.
REQ-004 I_clk_10M  in  1  system clock; all logic on its rising edge.
REQ-005 I_rst_n  in  1  asynchronous active-low reset.
REQ-006 I_trig  in  1  playback start request, sampled each cycle.
REQ-007 I_abort  in  1  synchronous playback cancel.
REQ-008 I_delay1..I_delay3  in  DW each  pre-segment wait in cycles (from the UART register decoder).
REQ-009 I_len1..I_len3  in  DW each  segment length in samples.
REQ-010 I_addr1..I_addr3  in  DW each  segment start address in waveform memory.
REQ-011 O_rd_en  out  1  waveform-memory read strobe, one sample per cycle.
REQ-012 O_rd_addr  out  DW  read address; valid only when O_rd_en=1.
REQ-013 O_seg  out  2  active segment, 0=idle, 1..3.
REQ-014 O_busy  out  1  playback in progress.
REQ-015 O_done  out  1  one-cycle end-of-playback pulse.
REQ-016 O_trig_miss  out  1  one-cycle pulse, trigger rejected while busy.

Function
REQ-017 States: IDLE, WAIT (delay countdown), PLAY (strobing), FIN (done pulse); all outputs registered.
REQ-018 In IDLE with I_trig=1 and I_abort=0 in cycle t0: latch all nine config inputs into shadow registers; config changes afterwards have no effect until the next accepted trigger.
REQ-019 Segment n play cycles start at t0+1+sum over k<n of (Dk+Lk)+Dn and last Ln consecutive cycles with O_rd_en=1.
REQ-020 Within segment n, O_rd_addr = An+i for sample i (0..Ln-1), modulo 2^DW (0xFFFFFF wraps to 0x000000).
REQ-021 Dn=0: no WAIT cycles for that segment; Ln=0: segment produces no O_rd_en, only its delay cycles elapse.
REQ-022 O_done=1 in exactly cycle t0+1+D1+L1+D2+L2+D3+L3 (t0+1 when all zero); state returns to IDLE next cycle.
REQ-023 O_busy=1 from cycle t0+1 through the O_done cycle inclusive; 0 otherwise.
REQ-024 O_seg = n during WAIT/PLAY of segment n, 3 in FIN, 0 in IDLE.
REQ-025 I_trig=1 while O_busy=1: trigger ignored, O_trig_miss=1 in the following cycle.
REQ-026 I_abort=1 (any state): next cycle IDLE, O_rd_en=0, O_busy=0, O_seg=0, no O_done.
REQ-027 I_abort and I_trig both 1 in the same cycle: abort wins, trigger dropped, no O_trig_miss.
REQ-028 Counters DW bits; maximum delay/length 2^DW-1 with no overflow or truncation.

Reset
REQ-029 I_rst_n=0 forces immediately: state IDLE, shadow registers 0, O_rd_en=0, O_rd_addr=0, O_seg=0, O_busy=0, O_done=0, O_trig_miss=0.
REQ-030 Reset asserted mid-playback aborts it with no O_done; after release the block waits for a new I_trig.

Structure
REQ-031 Shared package awg_seq_pkg holds the state enumeration, DW, NSEG and segment-index constants.
REQ-032 One sub-module, awg_seg_timer: loadable DW-bit down-counter with zero flag, reused for delay and length counting.

Verification
REQ-033 D=(2,0,1), L=(3,2,0), A=(0x10,0x200,0x300), trig at t0 -> rd_en t0+3..t0+5 addr 0x10..0x12, t0+6..t0+7 addr 0x200..0x201, done at t0+9.
REQ-034 All D and L zero, trig -> O_done at t0+1, O_busy only at t0+1, no O_rd_en.
REQ-035 A1=0xFFFFFE, L1=4, D1=0 -> addresses 0xFFFFFE, 0xFFFFFF, 0x000000, 0x000001.
REQ-036 Second trig during PLAY, and config inputs changed mid-playback -> O_trig_miss one cycle later, addresses and timing unchanged.
REQ-037 I_abort during segment 2 PLAY (and separately I_rst_n low) -> next cycle rd_en=0, busy=0, seg=0, no done; next trig plays normally.

Source files
------------

// File: rtl/awg_seq_pkg.sv
// Shared constants and types for the AWG segment sequencer.
package awg_seq_pkg;

    // Default field width for delay, length and address values.
    localparam int unsigned DefaultDw = 24;

    // Number of segments played per trigger (fixed at three in this revision).
    localparam int unsigned NumSeg = 3;

    // Sequencer control states.
    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StPlay,
        StFin
    } seq_state_e;

    // Segment indicator values as presented on O_seg.
    localparam logic [1:0] SegIdle  = 2'd0;
    localparam logic [1:0] SegFirst = 2'd1;
    localparam logic [1:0] SegLast  = 2'd3;

endpackage

// File: rtl/awg_seg_sequencer_if.sv
// Trigger, configuration and waveform-read bundle of the segment sequencer.
interface awg_seg_sequencer_if
    import awg_seq_pkg::*;
#(
    parameter int unsigned DW = DefaultDw
);

    logic          I_trig;
    logic          I_abort;
    logic [DW-1:0] I_delay1;
    logic [DW-1:0] I_delay2;
    logic [DW-1:0] I_delay3;
    logic [DW-1:0] I_len1;
    logic [DW-1:0] I_len2;
    logic [DW-1:0] I_len3;
    logic [DW-1:0] I_addr1;
    logic [DW-1:0] I_addr2;
    logic [DW-1:0] I_addr3;

    logic          O_rd_en;
    logic [DW-1:0] O_rd_addr;
    logic [1:0]    O_seg;
    logic          O_busy;
    logic          O_done;
    logic          O_trig_miss;

    // Register decoder / trigger source side.
    modport master (
        output I_trig, I_abort,
        output I_delay1, I_delay2, I_delay3,
        output I_len1, I_len2, I_len3,
        output I_addr1, I_addr2, I_addr3,
        input  O_rd_en, O_rd_addr, O_seg, O_busy, O_done, O_trig_miss
    );

    // Sequencer side.
    modport slave (
        input  I_trig, I_abort,
        input  I_delay1, I_delay2, I_delay3,
        input  I_len1, I_len2, I_len3,
        input  I_addr1, I_addr2, I_addr3,
        output O_rd_en, O_rd_addr, O_seg, O_busy, O_done, O_trig_miss
    );

endinterface

// File: rtl/awg_seg_timer.sv
// Loadable down-counter with a zero flag. The sequencer loads (cycles - 1), so
// the zero flag marks the last cycle of the current wait or play phase.
module awg_seg_timer
    import awg_seq_pkg::*;
#(
    parameter int unsigned DW = DefaultDw
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [DW-1:0] load_val,
    input  logic          dec,
    output logic          zero
);

    logic [DW-1:0] cnt;

    // Count register: load has priority, decrement saturates at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - DW'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/awg_seg_sequencer.sv
// Three-segment AWG playback sequencer. A trigger in idle snapshots the nine
// configuration words; each segment then waits Dn cycles and strobes Ln
// consecutive reads from An upward, followed by a single done cycle.
module awg_seg_sequencer
    import awg_seq_pkg::*;
#(
    parameter int unsigned DW   = DefaultDw,
    parameter int unsigned NSEG = NumSeg
) (
    input  logic               I_clk_10M,
    input  logic               I_rst_n,
    awg_seg_sequencer_if.slave bus
);

    seq_state_e    state_q, state_d;
    logic [1:0]    seg_q, seg_d;
    logic          rd_en_q, rd_en_d;
    logic [DW-1:0] rd_addr_q, rd_addr_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          trig_miss_q, trig_miss_d;

    logic [DW-1:0] in_dly [NSEG];
    logic [DW-1:0] in_len [NSEG];
    logic [DW-1:0] in_adr [NSEG];
    logic [DW-1:0] dly_q  [NSEG];
    logic [DW-1:0] len_q  [NSEG];
    logic [DW-1:0] adr_q  [NSEG];
    logic [DW-1:0] cfg_dly [NSEG];
    logic [DW-1:0] cfg_len [NSEG];
    logic [DW-1:0] cfg_adr [NSEG];

    logic          cap;
    logic          enter;
    int            enter_from;
    int            cur;
    logic          found;
    logic          tmr_load;
    logic [DW-1:0] tmr_val;
    logic          tmr_dec;
    logic          tmr_zero;

    assign in_dly[0] = bus.I_delay1;
    assign in_dly[1] = bus.I_delay2;
    assign in_dly[2] = bus.I_delay3;
    assign in_len[0] = bus.I_len1;
    assign in_len[1] = bus.I_len2;
    assign in_len[2] = bus.I_len3;
    assign in_adr[0] = bus.I_addr1;
    assign in_adr[1] = bus.I_addr2;
    assign in_adr[2] = bus.I_addr3;

    // Shadow copy of the configuration, taken only when a trigger is accepted.
    always_ff @(posedge I_clk_10M or negedge I_rst_n) begin
        if (!I_rst_n) begin
            for (int k = 0; k < NSEG; k++) begin
                dly_q[k] <= '0;
                len_q[k] <= '0;
                adr_q[k] <= '0;
            end
        end else if (cap) begin
            for (int k = 0; k < NSEG; k++) begin
                dly_q[k] <= in_dly[k];
                len_q[k] <= in_len[k];
                adr_q[k] <= in_adr[k];
            end
        end
    end

    // In idle the first segment is set up straight from the live inputs, since
    // the shadow copy only becomes visible one cycle after the trigger.
    always_comb begin
        for (int k = 0; k < NSEG; k++) begin
            cfg_dly[k] = (state_q == StIdle) ? in_dly[k] : dly_q[k];
            cfg_len[k] = (state_q == StIdle) ? in_len[k] : len_q[k];
            cfg_adr[k] = (state_q == StIdle) ? in_adr[k] : adr_q[k];
        end
    end

    // One timer serves both the delay and the length phase of every segment.
    awg_seg_timer #(
        .DW(DW)
    ) u_timer (
        .clk     (I_clk_10M),
        .rst_n   (I_rst_n),
        .load    (tmr_load),
        .load_val(tmr_val),
        .dec     (tmr_dec),
        .zero    (tmr_zero)
    );

    // Next state and next registered outputs.
    always_comb begin
        state_d     = state_q;
        seg_d       = seg_q;
        rd_en_d     = 1'b0;
        rd_addr_d   = rd_addr_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        trig_miss_d = 1'b0;
        cap         = 1'b0;
        enter       = 1'b0;
        enter_from  = 0;
        found       = 1'b0;
        tmr_load    = 1'b0;
        tmr_val     = '0;
        tmr_dec     = 1'b0;
        // Zero-based index of the active segment; only used in WAIT/PLAY.
        cur         = int'(seg_q) - 1;

        unique case (state_q)
            StIdle: begin
                seg_d = SegIdle;
                if (bus.I_trig) begin
                    cap        = 1'b1;
                    enter      = 1'b1;
                    enter_from = 0;
                end
            end
            StWait: begin
                if (!tmr_zero) begin
                    tmr_dec = 1'b1;
                end else if (cfg_len[cur] != '0) begin
                    state_d   = StPlay;
                    rd_en_d   = 1'b1;
                    rd_addr_d = cfg_adr[cur];
                    tmr_load  = 1'b1;
                    tmr_val   = cfg_len[cur] - DW'(1);
                end else begin
                    enter      = 1'b1;
                    enter_from = cur + 1;
                end
            end
            StPlay: begin
                if (!tmr_zero) begin
                    tmr_dec   = 1'b1;
                    rd_en_d   = 1'b1;
                    rd_addr_d = rd_addr_q + DW'(1);
                end else begin
                    enter      = 1'b1;
                    enter_from = cur + 1;
                end
            end
            StFin: begin
                state_d = StIdle;
                seg_d   = SegIdle;
            end
        endcase

        // Start the first segment at or after enter_from that has any cycles;
        // empty segments are skipped in the same cycle, and when none is left
        // the sequence goes straight to the done cycle.
        if (enter) begin
            state_d = StFin;
            seg_d   = SegLast;
            done_d  = 1'b1;
            for (int k = 0; k < NSEG; k++) begin
                if (!found && (k >= enter_from)) begin
                    if (cfg_dly[k] != '0) begin
                        found    = 1'b1;
                        state_d  = StWait;
                        seg_d    = 2'(k + 1);
                        done_d   = 1'b0;
                        tmr_load = 1'b1;
                        tmr_val  = cfg_dly[k] - DW'(1);
                    end else if (cfg_len[k] != '0) begin
                        found     = 1'b1;
                        state_d   = StPlay;
                        seg_d     = 2'(k + 1);
                        done_d    = 1'b0;
                        rd_en_d   = 1'b1;
                        rd_addr_d = cfg_adr[k];
                        tmr_load  = 1'b1;
                        tmr_val   = cfg_len[k] - DW'(1);
                    end
                end
            end
        end

        busy_d      = (state_d != StIdle);
        trig_miss_d = busy_q && bus.I_trig;

        // Abort overrides everything, including a coincident trigger.
        if (bus.I_abort) begin
            state_d     = StIdle;
            seg_d       = SegIdle;
            rd_en_d     = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b0;
            trig_miss_d = 1'b0;
            cap         = 1'b0;
            tmr_load    = 1'b0;
            tmr_dec     = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge I_clk_10M or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q     <= StIdle;
            seg_q       <= SegIdle;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            trig_miss_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            seg_q       <= seg_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            trig_miss_q <= trig_miss_d;
        end
    end

    assign bus.O_rd_en     = rd_en_q;
    assign bus.O_rd_addr   = rd_addr_q;
    assign bus.O_seg       = seg_q;
    assign bus.O_busy      = busy_q;
    assign bus.O_done      = done_q;
    assign bus.O_trig_miss = trig_miss_q;

endmodule

// File: tb/tb_awg_seg_sequencer.sv
// Bench for awg_seg_sequencer: directed scenarios plus random triggers/aborts,
// with a cycle-stamped scoreboard of expected outputs built from segment
// timing arithmetic and a monitor that compares every cycle.
`timescale 1ns/1ps
module tb_awg_seg_sequencer;
    import awg_seq_pkg::*;

    localparam int unsigned DW = DefaultDw;

    typedef struct {
        int            cyc;
        logic          busy;
        logic [1:0]    seg;
        logic          rd_en;
        logic [DW-1:0] addr;
        logic          done;
    } rec_t;

    logic clk;
    logic rst_n;
    int   cyc;
    logic mon_on;
    int   checks;
    int   errors;
    int   busy_lo;
    int   busy_hi;
    rec_t exp_q[$];
    int   miss_q[$];

    awg_seg_sequencer_if #(.DW(DW)) bus ();

    awg_seg_sequencer #(
        .DW  (DW),
        .NSEG(NumSeg)
    ) dut (
        .I_clk_10M(clk),
        .I_rst_n  (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic rec_t mk(input int c, input logic b, input logic [1:0] s,
                                input logic r, input logic [DW-1:0] a, input logic d);
        rec_t x;
        x.cyc = c; x.busy = b; x.seg = s; x.rd_en = r; x.addr = a; x.done = d;
        return x;
    endfunction

    // Expected behaviour of an accepted trigger at cycle c: segment n waits
    // Dn cycles then reads An+i for Ln cycles; one done cycle follows.
    task automatic model_accept(input int c);
        logic [DW-1:0] d[3];
        logic [DW-1:0] l[3];
        logic [DW-1:0] a[3];
        int t;
        d[0] = bus.I_delay1; d[1] = bus.I_delay2; d[2] = bus.I_delay3;
        l[0] = bus.I_len1;   l[1] = bus.I_len2;   l[2] = bus.I_len3;
        a[0] = bus.I_addr1;  a[1] = bus.I_addr2;  a[2] = bus.I_addr3;
        t = c + 1;
        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < int'(d[n]); i++) begin
                exp_q.push_back(mk(t, 1'b1, 2'(n + 1), 1'b0, '0, 1'b0));
                t++;
            end
            for (int i = 0; i < int'(l[n]); i++) begin
                exp_q.push_back(mk(t, 1'b1, 2'(n + 1), 1'b1, a[n] + DW'(i), 1'b0));
                t++;
            end
        end
        exp_q.push_back(mk(t, 1'b1, 2'd3, 1'b0, '0, 1'b1));
        busy_lo = c + 1;
        busy_hi = t;
    endtask

    // Drop every expectation later than cycle c.
    task automatic flush_after(input int c);
        while (exp_q.size() > 0 && exp_q[exp_q.size() - 1].cyc > c) void'(exp_q.pop_back());
        while (miss_q.size() > 0 && miss_q[miss_q.size() - 1] > c) void'(miss_q.pop_back());
        if (busy_hi > c) busy_hi = c;
    endtask

    // Drive trig/abort for the current cycle, update the model, advance.
    task automatic step(input logic trig, input logic abort);
        int c;
        c = cyc;
        bus.I_trig  = trig;
        bus.I_abort = abort;
        if (abort) begin
            flush_after(c);
        end else if (trig) begin
            if (c >= busy_lo && c <= busy_hi) miss_q.push_back(c + 1);
            else model_accept(c);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    task automatic set_cfg(input int d1, input int d2, input int d3,
                           input int l1, input int l2, input int l3,
                           input int a1, input int a2, input int a3);
        bus.I_delay1 = DW'(d1); bus.I_delay2 = DW'(d2); bus.I_delay3 = DW'(d3);
        bus.I_len1   = DW'(l1); bus.I_len2   = DW'(l2); bus.I_len3   = DW'(l3);
        bus.I_addr1  = DW'(a1); bus.I_addr2  = DW'(a2); bus.I_addr3  = DW'(a3);
    endtask

    function automatic int rand_addr();
        if ($urandom_range(0, 3) == 0) return 32'h00FF_FFFF - int'($urandom_range(0, 3));
        return int'($urandom_range(0, 32'h00FF_FFFF));
    endfunction

    task automatic rand_cfg();
        set_cfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                rand_addr(), rand_addr(), rand_addr());
    endtask

    // Reset in the middle of whatever is running; nothing after it is expected.
    task automatic do_reset();
        bus.I_trig  = 1'b0;
        bus.I_abort = 1'b0;
        rst_n = 1'b0;
        flush_after(cyc - 1);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare DUT outputs with the scoreboard every cycle.
    always @(negedge clk) begin : monitor
        rec_t e;
        logic em;
        if (mon_on) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL stale_expect cycle %0d: expected entry for cycle %0d never matched",
                         cyc, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            e = mk(cyc, 1'b0, 2'd0, 1'b0, '0, 1'b0);
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) e = exp_q.pop_front();
            checks++;
            if (bus.O_busy !== e.busy || bus.O_seg !== e.seg || bus.O_rd_en !== e.rd_en ||
                bus.O_done !== e.done || (e.rd_en && bus.O_rd_addr !== e.addr) ||
                (!rst_n && bus.O_rd_addr !== '0)) begin
                errors++;
                $display("FAIL outputs cycle %0d: got busy=%0b seg=%0d rd_en=%0b addr=%h done=%0b, want busy=%0b seg=%0d rd_en=%0b addr=%h done=%0b",
                         cyc, bus.O_busy, bus.O_seg, bus.O_rd_en, bus.O_rd_addr, bus.O_done,
                         e.busy, e.seg, e.rd_en, e.addr, e.done);
            end
            while (miss_q.size() > 0 && miss_q[0] < cyc) void'(miss_q.pop_front());
            em = (miss_q.size() > 0 && miss_q[0] == cyc);
            if (em) void'(miss_q.pop_front());
            checks++;
            if (bus.O_trig_miss !== em) begin
                errors++;
                $display("FAIL trig_miss cycle %0d: got %0b want %0b", cyc, bus.O_trig_miss, em);
            end
        end
    end

    initial begin
        cyc     = 0;
        checks  = 0;
        errors  = 0;
        busy_lo = 1;
        busy_hi = 0;
        mon_on  = 1'b0;
        rst_n   = 1'b1;
        bus.I_trig  = 1'b0;
        bus.I_abort = 1'b0;
        set_cfg(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        rst_n  = 1'b0;
        mon_on = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle(2);

        // Reference sequence with a zero delay and a zero-length segment.
        set_cfg(2, 0, 1, 3, 2, 0, 'h10, 'h200, 'h300);
        step(1'b1, 1'b0);
        idle(12);

        // Everything zero: done immediately after the trigger.
        set_cfg(0, 0, 0, 0, 0, 0, 'h55, 'h66, 'h77);
        step(1'b1, 1'b0);
        idle(4);

        // Address wrap at the top of the address space.
        set_cfg(0, 0, 0, 4, 0, 0, 'hFFFFFE, 0, 0);
        step(1'b1, 1'b0);
        idle(8);

        // Retrigger during play while the config inputs keep changing.
        set_cfg(1, 0, 2, 4, 3, 1, 'h1000, 'h2000, 'h3000);
        step(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin rand_cfg(); step(1'b0, 1'b0); end
        rand_cfg();
        step(1'b1, 1'b0);
        for (int i = 0; i < 14; i++) begin rand_cfg(); step(1'b0, 1'b0); end

        // Abort (with a coincident trigger) during segment 2 play, then replay.
        set_cfg(1, 1, 1, 2, 3, 2, 'h400, 'h500, 'h600);
        step(1'b1, 1'b0);
        idle(5);
        step(1'b1, 1'b1);
        idle(2);
        step(1'b1, 1'b0);
        idle(14);

        // Reset during segment 2 play, then replay.
        step(1'b1, 1'b0);
        idle(6);
        do_reset();
        idle(2);
        step(1'b1, 1'b0);
        idle(14);

        // Random triggers, aborts and config churn.
        for (int i = 0; i < 400; i++) begin
            rand_cfg();
            step(($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0);
        end
        idle(40);

        checks++;
        if (exp_q.size() != 0 || miss_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d output and %0d miss expectations left, want 0 and 0",
                     exp_q.size(), miss_q.size());
        end
        mon_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
